// File: rtl/bridge_pkg.sv
// Shared types and bus widths for the two-port bridge arbiter.
package bridge_pkg;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 16;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } bridge_cmd_t;

endpackage

// File: rtl/bridge_arbiter_if.sv
// Requester ports and bridge-master signals of the arbiter; slave = arbiter view, master = environment view.
interface bridge_arbiter_if;
    import bridge_pkg::*;

    logic              req0, we0, ack0, err0;
    logic [ADDR_W-1:0] addr0;
    logic [BE_W-1:0]   be0;
    logic [DATA_W-1:0] wdata0, rdata0;

    logic              req1, we1, ack1, err1;
    logic [ADDR_W-1:0] addr1;
    logic [BE_W-1:0]   be1;
    logic [DATA_W-1:0] wdata1, rdata1;

    logic [ADDR_W-1:0] bridge_address;
    logic [BE_W-1:0]   bridge_byte_enable;
    logic              bridge_read, bridge_write, bridge_acknowledge;
    logic [DATA_W-1:0] bridge_write_data, bridge_read_data;
    logic              timeout_sticky, busy;

    modport slave (
        input  req0, we0, addr0, be0, wdata0,
        input  req1, we1, addr1, be1, wdata1,
        input  bridge_acknowledge, bridge_read_data,
        output ack0, rdata0, err0, ack1, rdata1, err1,
        output bridge_address, bridge_byte_enable, bridge_read, bridge_write, bridge_write_data,
        output timeout_sticky, busy
    );

    modport master (
        output req0, we0, addr0, be0, wdata0,
        output req1, we1, addr1, be1, wdata1,
        output bridge_acknowledge, bridge_read_data,
        input  ack0, rdata0, err0, ack1, rdata1, err1,
        input  bridge_address, bridge_byte_enable, bridge_read, bridge_write, bridge_write_data,
        input  timeout_sticky, busy
    );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port not granted last.
module rr_pick2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic valid_o,
    output logic grant_o
);

    assign valid_o = req0_i | req1_i;
    assign grant_o = (req0_i & req1_i) ? ~last_grant_i : req1_i;

endmodule

// File: rtl/bridge_arbiter.sv
// Shares the bridge master between two requesters, one registered transaction at a time.
// state | meaning
// IDLE  | no command on the bridge, waiting for a request
// BUSY  | command held on the bridge until acknowledge or watchdog expiry
// DONE  | one-cycle ack (and err) to the granted port
module bridge_arbiter
    import bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk_clk,
    input  logic            reset_reset_n,
    bridge_arbiter_if.slave bus
);

    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    bridge_cmd_t       cmd_q, cmd_d, win_cmd;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic              grant_q, grant_d, last_grant_q, last_grant_d;
    logic              err_q, err_d, sticky_q, sticky_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              pick_valid, pick_grant;

    rr_pick2 u_pick (
        .req0_i      (bus.req0),
        .req1_i      (bus.req1),
        .last_grant_i(last_grant_q),
        .valid_o     (pick_valid),
        .grant_o     (pick_grant)
    );

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
            sticky_q     <= 1'b0;
            timer_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
            sticky_q     <= sticky_d;
            timer_q      <= timer_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        err_d        = err_q;
        sticky_d     = sticky_q;
        timer_d      = timer_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        win_cmd.we    = pick_grant ? bus.we1    : bus.we0;
        win_cmd.addr  = pick_grant ? bus.addr1  : bus.addr0;
        win_cmd.be    = pick_grant ? bus.be1    : bus.be0;
        win_cmd.wdata = pick_grant ? bus.wdata1 : bus.wdata0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    cmd_d        = win_cmd;
                    rd_d         = ~win_cmd.we;
                    wr_d         = win_cmd.we;
                    grant_d      = pick_grant;
                    last_grant_d = pick_grant;
                    err_d        = 1'b0;
                    timer_d      = TMR_LOAD;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                // Acknowledge is tested first so a late ack on the expiry cycle still succeeds.
                if (bus.bridge_acknowledge) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = DONE;
                    if (!cmd_q.we) begin
                        if (grant_q) rdata1_d = bus.bridge_read_data;
                        else         rdata0_d = bus.bridge_read_data;
                    end
                end else if (timer_q == '0) begin
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    err_d    = 1'b1;
                    sticky_d = 1'b1;
                    state_d  = DONE;
                    if (!cmd_q.we) begin
                        if (grant_q) rdata1_d = '0;
                        else         rdata0_d = '0;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ack0 = (state_q == DONE) && !grant_q;
    assign bus.ack1 = (state_q == DONE) && grant_q;
    assign bus.err0 = bus.ack0 && err_q;
    assign bus.err1 = bus.ack1 && err_q;
    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;

    assign bus.bridge_address     = cmd_q.addr;
    assign bus.bridge_byte_enable = cmd_q.be;
    assign bus.bridge_write_data  = cmd_q.wdata;
    assign bus.bridge_read        = rd_q;
    assign bus.bridge_write       = wr_q;

    assign bus.timeout_sticky = sticky_q;
    assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_bridge_arbiter.sv
// Random two-port traffic against a transaction-timeline model of the arbiter.
module tb_bridge_arbiter;
    import bridge_pkg::*;

    localparam int TO         = 8;
    localparam int N_CYC      = 3000;
    localparam int CONT_START = 1000;
    localparam int CONT_END   = 1800;
    localparam int MID_RST    = 2000;

    logic clk_clk       = 1'b0;
    logic reset_reset_n = 1'b0;
    int   n_checks      = 0;
    int   n_fail        = 0;
    int   s             = 0;

    bridge_arbiter_if bus ();

    bridge_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .bus          (bus)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s sample=%0d got=%0h expected=%0h", tag, s, got, exp);
        end
    endtask

    function automatic bridge_cmd_t rand_cmd();
        bridge_cmd_t c;
        c.we = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
            0:       c.addr = '0;
            1:       c.addr = '1;
            default: c.addr = ADDR_W'($urandom);
        endcase
        c.be    = BE_W'($urandom);
        c.wdata = DATA_W'($urandom);
        return c;
    endfunction

    initial begin
        bridge_cmd_t       port_cmd [2];
        bit                port_req [2];
        logic [DATA_W-1:0] exp_rd [2];
        bridge_cmd_t       gcmd;
        logic [DATA_W-1:0] resp;
        logic [1:0]        exp_ack, exp_err, obs_ack;
        bit                infl, mid_done, sticky, rst_seen, rst_next, done_now, bus_on;
        int                win, gstart, lat, m, idle_from, last_g, rst_hold, req_pct, pick;

        infl = 0; mid_done = 0; sticky = 0;
        win = 0; gstart = 0; lat = 0; m = 0; idle_from = 0; last_g = 1; rst_hold = 0;
        resp = '0; gcmd = '0;
        for (int p = 0; p < 2; p++) begin
            port_req[p] = 0;
            port_cmd[p] = '0;
            exp_rd[p]   = '0;
        end
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.be0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.be1 = '0; bus.wdata1 = '0;
        bus.bridge_acknowledge = 0;
        bus.bridge_read_data   = '0;

        for (int i = 0; i < N_CYC; i++) begin
            @(negedge clk_clk);
            s        = i;
            rst_seen = !reset_reset_n;
            obs_ack  = {bus.ack1, bus.ack0};

            if (rst_seen) begin
                infl      = 0;
                last_g    = 1;
                sticky    = 0;
                exp_rd[0] = '0;
                exp_rd[1] = '0;
                idle_from = i;
                chk_eq("reset_cmd", 64'({bus.bridge_read, bus.bridge_write, bus.bridge_address,
                                          bus.bridge_byte_enable, bus.bridge_write_data}), 64'(0));
            end

            // Where are we on the current transaction's timeline?
            done_now = infl && (i == gstart + m);
            bus_on   = infl && (i >= gstart) && (i < gstart + m);
            exp_ack  = '0;
            exp_err  = '0;
            if (done_now) begin
                infl         = 0;
                idle_from    = i + 1;
                exp_ack[win] = 1'b1;
                if (lat > TO) begin
                    exp_err[win] = 1'b1;
                    sticky       = 1;
                    if (!gcmd.we) exp_rd[win] = '0;
                end else if (!gcmd.we) begin
                    exp_rd[win] = resp;
                end
            end

            if (bus_on)
                chk_eq("bridge_cmd", 64'({bus.bridge_read, bus.bridge_write, bus.bridge_address,
                                           bus.bridge_byte_enable, bus.bridge_write_data}),
                       64'({~gcmd.we, gcmd.we, gcmd.addr, gcmd.be, gcmd.wdata}));
            else
                chk_eq("bridge_rw_off", 64'({bus.bridge_read, bus.bridge_write}), 64'(0));
            chk_eq("ack", 64'(obs_ack), 64'(exp_ack));
            chk_eq("err", 64'({bus.err1, bus.err0}), 64'(exp_err));
            chk_eq("rdata0", 64'(bus.rdata0), 64'(exp_rd[0]));
            chk_eq("rdata1", 64'(bus.rdata1), 64'(exp_rd[1]));
            chk_eq("timeout_sticky", 64'(bus.timeout_sticky), 64'(sticky));
            chk_eq("busy", 64'(bus.busy), 64'(bus_on || done_now));

            // Reset: power-on, then once in the middle of a read on the bridge.
            if (i >= MID_RST && !mid_done && bus_on && !gcmd.we) begin
                mid_done = 1;
                rst_hold = 3;
            end
            rst_next = (i < 4) || (rst_hold > 0);
            if (rst_hold > 0) rst_hold--;
            reset_reset_n = !rst_next;

            // Requesters: hold until ack, then drop; both request on reset release.
            req_pct = (i >= CONT_START && i < CONT_END) ? 100 : 35;
            for (int p = 0; p < 2; p++) begin
                if (rst_next) begin
                    port_req[p] = 0;
                end else if (port_req[p]) begin
                    if (obs_ack[p])
                        port_req[p] = 0;
                    else if (!(infl && win == p) && $urandom_range(0, 1) == 1)
                        port_cmd[p] = rand_cmd();
                end else if (rst_seen || $urandom_range(0, 99) < req_pct) begin
                    port_req[p] = 1;
                    port_cmd[p] = rand_cmd();
                end
            end

            if (!infl && !rst_next && i >= idle_from && (port_req[0] || port_req[1])) begin
                if (port_req[0] && port_req[1]) win = 1 - last_g;
                else                            win = port_req[1] ? 1 : 0;
                last_g = win;
                gcmd   = port_cmd[win];
                infl   = 1;
                gstart = i + 1;
                pick   = int'($urandom_range(0, 9));
                if (pick == 0)      lat = TO;
                else if (pick <= 2) lat = TO + 1;
                else                lat = int'($urandom_range(1, 4));
                m    = (lat > TO) ? TO : lat;
                resp = DATA_W'($urandom);
            end

            bus.req0 = port_req[0]; bus.we0 = port_cmd[0].we; bus.addr0 = port_cmd[0].addr;
            bus.be0 = port_cmd[0].be; bus.wdata0 = port_cmd[0].wdata;
            bus.req1 = port_req[1]; bus.we1 = port_cmd[1].we; bus.addr1 = port_cmd[1].addr;
            bus.be1 = port_cmd[1].be; bus.wdata1 = port_cmd[1].wdata;

            // Bridge: ack on the chosen command cycle, stray acks only outside the command window.
            bus.bridge_acknowledge = 1'b0;
            bus.bridge_read_data   = DATA_W'($urandom);
            if (infl && lat <= TO && i == gstart + lat - 1) begin
                bus.bridge_acknowledge = 1'b1;
                bus.bridge_read_data   = resp;
            end else if (!(infl && i >= gstart && i < gstart + m) && $urandom_range(0, 3) == 0) begin
                bus.bridge_acknowledge = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bridge_arbiter.md
Name: bridge_arbiter

Overview:
Two-port round-robin arbiter that shares the SoC's 16-bit external bridge master (26-bit address, 2-bit byte enable, read/write, acknowledge) between two fabric requesters. Port 0 is the audio sample fetcher (reads PCM from SDRAM); port 1 is the decoder/SD write path. The block registers one transaction at a time, holds it stable on the bridge until acknowledge, and returns a one-cycle ack with read data. A watchdog aborts transactions the bridge never acknowledges.

Parameters:
ADDR_W, 26, bridge address width
DATA_W, 16, bridge data width
BE_W, 2, byte-enable width (DATA_W/8)
TIMEOUT_CYCLES, 1024, cycles in BUSY without acknowledge before abort; minimum 2

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  synchronous active-low reset
req0  in  1  port 0 request, held until ack0
we0  in  1  port 0: 1 = write, 0 = read
addr0  in  ADDR_W  port 0 address
be0  in  BE_W  port 0 byte enables
wdata0  in  DATA_W  port 0 write data
ack0  out  1  port 0 one-cycle completion pulse
rdata0  out  DATA_W  port 0 read data, valid with ack0
err0  out  1  port 0 completion was a timeout, valid with ack0
req1, we1, addr1, be1, wdata1, ack1, rdata1, err1  as port 0, for port 1
bridge_address  out  ADDR_W  to bridge
bridge_byte_enable  out  BE_W  to bridge
bridge_read  out  1  to bridge
bridge_write  out  1  to bridge
bridge_write_data  out  DATA_W  to bridge
bridge_acknowledge  in  1  from bridge
bridge_read_data  in  DATA_W  from bridge
timeout_sticky  out  1  set on any timeout; cleared only by reset
busy  out  1  high in any state except IDLE

Behaviour:
- Clocking and reset: one clock (clk_clk). Reset is synchronous and active-low (reset_reset_n). On reset the state is IDLE and all outputs are 0: bridge_read, bridge_write, address, byte enable, write data, ack*, rdata*, err*, timeout_sticky, busy. last_grant resets to 1, so port 0 wins the first contention. Reset asserted mid-transaction drops the bridge command on the next edge and does not issue an ack.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If either req is high, choose a winner. If only one port requests, it wins. If both request, the port not equal to last_grant wins.
  - On that edge, latch the winner's we/addr/be/wdata into the bridge output registers, assert bridge_read=~we or bridge_write=we, record grant and last_grant, clear the timer, and go to BUSY.
  - A request seen at cycle N appears on the bridge at cycle N+1.
- BUSY:
  - Bridge outputs are held constant.
  - If bridge_acknowledge=1: on that edge drop bridge_read and bridge_write, capture bridge_read_data into the granted port's rdata (writes leave rdata unchanged), and go to DONE.
  - Else increment the timer. When the timer reaches TIMEOUT_CYCLES-1 without acknowledge: drop the command, set err for the granted port, set timeout_sticky, go to DONE; rdata is 0 for a timed-out read.
  - Acknowledge arriving in the same cycle as timer expiry counts as success.
- DONE: exactly one cycle. ack of the granted port is 1 and err is valid with it. Then go to IDLE. ack and err are 0 in every other state.
- Requester contract: req is held with stable command fields until ack is sampled, then deasserted on that same edge. A req still high in the IDLE cycle after DONE is treated as a new request.
- bridge_acknowledge in IDLE or DONE is ignored.
- The ungranted port's fields may change freely.
- Minimum transaction: request cycle N, bridge command N+1, acknowledge at N+1 gives ack at N+2, and the next grant is possible at N+3.
- Under continuous contention the ports strictly alternate.

Decomposition:
- Shared package bridge_pkg: state enum (IDLE/BUSY/DONE), ADDR_W/DATA_W/BE_W constants, and a bridge_cmd struct {we, addr, be, wdata}.
- Sub-module rr_pick2: combinational round-robin choice from {req0, req1, last_grant} to {valid, grant}. Everything else, including the timer, stays in the top.

Test Plan:
- Single read: req0 read at addr 0x0001234; bridge acknowledges 3 cycles after bridge_read with data 0xBEEF -> bridge_address=0x0001234 and bridge_read=1 from N+1 for 3 cycles, then ack0=1 with rdata0=0xBEEF and err0=0 one cycle after acknowledge.
- Write: req1 write to addr 0x3FFFFFF, be=2'b10, wdata 0xA55A -> bridge_write=1 with those values held stable until acknowledge; ack1 pulses once; rdata1 unchanged.
- Contention: req0 and req1 both held high for 4 transactions each -> bridge grants in order 0,1,0,1,... and no port is served twice in a row.
- Timeout: TIMEOUT_CYCLES=8, req0 read, acknowledge never asserted -> command dropped after 8 BUSY cycles; ack0=1, err0=1, rdata0=0; timeout_sticky=1 and stays 1 through later good transactions.
- Reset mid-BUSY: assert reset_reset_n=0 during bridge_read -> next edge all outputs 0, state IDLE, no ack; after release, a fresh req0 completes normally with port 0 winning first.
- Boundary: acknowledge on the same cycle as timer expiry -> err0=0 and rdata0 holds the bridge data. Stray acknowledge in IDLE -> no ack and no state change.
